sync_mod_counter: RTL and testbench

//  Fully synchronous, parametrised up/down modulo counter; next generation of the 4-bit
//  T-flip-flop ripple counter. Single clock domain, no derived clocks. Adds a programmable

---
 rtl/cnt_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 55 +++++
 rtl/sync_mod_counter.sv | 120 ++++++++++++
 tb/tb_sync_mod_counter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// ----------------------------------------------------------------------------
// cnt_pkg
//   Shared constants and helpers for the synchronous modulo counter family.
//   - CNT_MODE_WRAP / CNT_MODE_SAT : legal values of the SATURATE parameter.
//   - pcnt_width()                 : register width needed by the prescaler to
//                                    hold counts 0..PRESCALE-1.
// ----------------------------------------------------------------------------
package cnt_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // At least one bit, even for PRESCALE values where $clog2 would give 0.
    function automatic int pcnt_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage : cnt_pkg

// File: rtl/counter_prescaler.sv
// ----------------------------------------------------------------------------
// counter_prescaler
//   Divides the count enable so that one step is issued every PRESCALE
//   enabled cycles. Only instantiated when PRESCALE >= 2.
// Ports
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears the phase count
//   en     in   advance the phase count this cycle
//   clr    in   restart the phase count at 0 (wins over en)
//   step   out  combinational: en is high and the phase count is at its last value
// ----------------------------------------------------------------------------
module counter_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int            PW        = pcnt_width(PRESCALE);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          at_last;

    assign at_last = (pcnt_q == PCNT_LAST);

    // Not gated by clr here; the top suppresses the step when a load is present.
    assign step = en && at_last;

    always_comb begin
        // NOTE: default assignment first so every path assigns pcnt_d and no latch is inferred.
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = at_last ? '0 : pcnt_q + PW'(1);
        end
    end

    // NOTE: non-blocking assignment for registered state so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule : counter_prescaler

// File: rtl/sync_mod_counter.sv
// ----------------------------------------------------------------------------
// sync_mod_counter
//   Fully synchronous up/down modulo counter with parallel load, prescaled
//   enable, wrap/saturate behaviour at the ends of the range, a combinational
//   terminal-count strobe and a sticky overflow flag.
// Parameters
//   WIDTH     counter width (>= 2)
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SATURATE  CNT_MODE_WRAP or CNT_MODE_SAT
//   PRESCALE  one step per PRESCALE enabled cycles (>= 1)
// Ports
//   clk       in   clock
//   reset     in   synchronous active-high reset (highest priority)
//   en        in   count enable
//   up_dn     in   1 = up, 0 = down
//   load      in   parallel load strobe (beats counting)
//   load_val  in   load value, clamped to MODULUS-1
//   clr_ovf   in   clears ovf (a simultaneous tc wins)
//   q         out  registered count
//   tc        out  combinational terminal-count strobe
//   ovf       out  registered sticky overflow/underflow flag
// ----------------------------------------------------------------------------
module sync_mod_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = CNT_MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Terminal value held as a WIDTH-bit constant so no arithmetic needs a wider result.
    localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 1);
    localparam bit               SAT_MODE = (SATURATE == CNT_MODE_SAT);

`ifndef SYNTHESIS
    initial begin
        if (WIDTH < 2 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
            PRESCALE < 1) begin
            $error("sync_mod_counter: illegal parameters WIDTH=%0d MODULUS=%0d PRESCALE=%0d",
                   WIDTH, MODULUS, PRESCALE);
        end
    end
`endif

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step;
    logic             at_term;

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign step = en;
        end else begin : g_prescale
            counter_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .clr   (load),
                .step  (step)
            );
        end
    endgenerate

    // The end of the range depends on the direction sampled in this same cycle.
    assign at_term = up_dn ? (q_q == Q_MAX) : (q_q == '0);
    assign tc      = step && !load && !reset && at_term;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val > Q_MAX) ? Q_MAX : load_val;
        end else if (step) begin
            if (up_dn) begin
                q_d = (q_q == Q_MAX) ? (SAT_MODE ? Q_MAX : '0) : q_q + WIDTH'(1);
            end else begin
                q_d = (q_q == '0) ? (SAT_MODE ? '0 : Q_MAX) : q_q - WIDTH'(1);
            end
        end
    end

    // Setting from tc takes precedence over clearing.
    always_comb begin
        ovf_d = ovf_q;
        if (tc) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule : sync_mod_counter

// File: tb/tb_sync_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_mod_counter
//   Three counter instances, all WIDTH=4 MODULUS=10:
//     index 0: wrap,     no prescale
//     index 1: saturate, no prescale
//     index 2: wrap,     PRESCALE=3
//   Inputs change 1 ns after a rising edge; tc is sampled 1 ns after the
//   inputs change, q/ovf 1 ns after the following rising edge.
// ----------------------------------------------------------------------------
module tb_sync_mod_counter;

    logic            clk;
    logic [2:0]      rst;
    logic [2:0]      en;
    logic [2:0]      up_dn;
    logic [2:0]      load;
    logic [2:0]      clr_ovf;
    logic [2:0][3:0] load_val;
    logic [2:0][3:0] q;
    logic [2:0]      tc;
    logic [2:0]      ovf;

    int checks = 0;
    int errors = 0;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) dut_wrap (
        .clk(clk), .reset(rst[0]), .en(en[0]), .up_dn(up_dn[0]), .load(load[0]),
        .load_val(load_val[0]), .clr_ovf(clr_ovf[0]), .q(q[0]), .tc(tc[0]), .ovf(ovf[0])
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_sat (
        .clk(clk), .reset(rst[1]), .en(en[1]), .up_dn(up_dn[1]), .load(load[1]),
        .load_val(load_val[1]), .clr_ovf(clr_ovf[1]), .q(q[1]), .tc(tc[1]), .ovf(ovf[1])
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
        .clk(clk), .reset(rst[2]), .en(en[2]), .up_dn(up_dn[2]), .load(load[2]),
        .load_val(load_val[2]), .clr_ovf(clr_ovf[2]), .q(q[2]), .tc(tc[2]), .ovf(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = '1; en = '0; up_dn = '1; load = '0; clr_ovf = '0; load_val = '0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k] !== 4'd0) begin errors++; $display("FAIL reset_q[%0d]: got %0d want 0", k, q[k]); end
            checks++;
            if (ovf[k] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf[k]); end
            checks++;
            if (tc[k] !== 1'b0) begin errors++; $display("FAIL reset_tc[%0d]: got %b want 0", k, tc[k]); end
        end
        rst = '0;

        // Build up state on instance 0 (q=9, ovf=1), then reset with en held high.
        load[0] = 1'b1; load_val[0] = 4'd9;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        tick();
        en[0] = 1'b0; load[0] = 1'b1;
        tick();
        load[0] = 1'b0; en[0] = 1'b1; rst[0] = 1'b1;
        #1;
        checks++;
        if (tc[0] !== 1'b0) begin errors++; $display("FAIL reset_tc_masked: got %b want 0", tc[0]); end
        tick();
        checks++;
        if (q[0] !== 4'd0) begin errors++; $display("FAIL reset_mid_q: got %0d want 0", q[0]); end
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_ovf: got %b want 0", ovf[0]); end
        tick();
        tick();
        checks++;
        if (q[0] !== 4'd0) begin errors++; $display("FAIL reset_held_q: got %0d want 0", q[0]); end
        rst[0] = 1'b0; en[0] = 1'b0;

        // Reset mid-prescale on instance 2 must discard the phase count.
        en[2] = 1'b1;
        tick();
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        tick();
        tick();
        checks++;
        if (q[2] !== 4'd0) begin errors++; $display("FAIL reset_prescale_q: got %0d want 0", q[2]); end
        en[2] = 1'b0;
    endtask

    task automatic test_wrap_up();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; en[0] = 1'b1; up_dn[0] = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            #1;
            checks++;
            if (q[0] !== 4'(i % 10)) begin errors++; $display("FAIL wrap_up_q step %0d: got %0d want %0d", i, q[0], i % 10); end
            checks++;
            if (tc[0] !== (i == 9)) begin errors++; $display("FAIL wrap_up_tc step %0d: got %b want %b", i, tc[0], i == 9); end
            checks++;
            if (ovf[0] !== (i == 10)) begin errors++; $display("FAIL wrap_up_ovf step %0d: got %b want %b", i, ovf[0], i == 10); end
            tick();
        end
        en[0] = 1'b0;
    endtask

    task automatic test_wrap_down();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; en[0] = 1'b1; up_dn[0] = 1'b0;
        #1;
        checks++;
        if (tc[0] !== 1'b1) begin errors++; $display("FAIL wrap_down_tc: got %b want 1", tc[0]); end
        tick();
        checks++;
        if (q[0] !== 4'd9) begin errors++; $display("FAIL wrap_down_q: got %0d want 9", q[0]); end
        checks++;
        if (ovf[0] !== 1'b1) begin errors++; $display("FAIL wrap_down_ovf: got %b want 1", ovf[0]); end
        checks++;
        if (tc[0] !== 1'b0) begin errors++; $display("FAIL wrap_down_tc9: got %b want 0", tc[0]); end
        tick();
        checks++;
        if (q[0] !== 4'd8) begin errors++; $display("FAIL wrap_down_q8: got %0d want 8", q[0]); end
        en[0] = 1'b0;
    endtask

    task automatic test_saturate();
        en[1] = 1'b1; up_dn[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q[1] !== 4'd0) begin errors++; $display("FAIL sat_low_q %0d: got %0d want 0", i, q[1]); end
            checks++;
            if (tc[1] !== 1'b1) begin errors++; $display("FAIL sat_low_tc %0d: got %b want 1", i, tc[1]); end
            tick();
        end
        checks++;
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL sat_low_ovf: got %b want 1", ovf[1]); end
        en[1] = 1'b0; load[1] = 1'b1; load_val[1] = 4'd8;
        tick();
        load[1] = 1'b0; en[1] = 1'b1; up_dn[1] = 1'b1;
        #1;
        checks++;
        if (tc[1] !== 1'b0) begin errors++; $display("FAIL sat_high_tc8: got %b want 0", tc[1]); end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q[1] !== 4'd9) begin errors++; $display("FAIL sat_high_q %0d: got %0d want 9", i, q[1]); end
            #1;
            checks++;
            if (tc[1] !== 1'b1) begin errors++; $display("FAIL sat_high_tc %0d: got %b want 1", i, tc[1]); end
            tick();
        end
        checks++;
        if (q[1] !== 4'd9) begin errors++; $display("FAIL sat_high_hold: got %0d want 9", q[1]); end
        en[1] = 1'b0;
    endtask

    task automatic test_load();
        int exp_q [3] = '{3, 3, 4};
        load[0] = 1'b1; load_val[0] = 4'd9; en[0] = 1'b0;
        tick();
        checks++;
        if (q[0] !== 4'd9) begin errors++; $display("FAIL load_9: got %0d want 9", q[0]); end
        // q is at the terminal value; the load must suppress both step and tc.
        load_val[0] = 4'd15; en[0] = 1'b1; up_dn[0] = 1'b1;
        #1;
        checks++;
        if (tc[0] !== 1'b0) begin errors++; $display("FAIL load_tc: got %b want 0", tc[0]); end
        tick();
        checks++;
        if (q[0] !== 4'd9) begin errors++; $display("FAIL load_clamp15: got %0d want 9", q[0]); end
        load_val[0] = 4'd10;
        tick();
        checks++;
        if (q[0] !== 4'd9) begin errors++; $display("FAIL load_clamp10: got %0d want 9", q[0]); end
        load_val[0] = 4'd3; en[0] = 1'b0;
        tick();
        checks++;
        if (q[0] !== 4'd3) begin errors++; $display("FAIL load_3: got %0d want 3", q[0]); end
        load[0] = 1'b0;

        // Load mid-prescale restarts the phase count.
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0; en[2] = 1'b1; up_dn[2] = 1'b1;
        tick();
        tick();
        load[2] = 1'b1; load_val[2] = 4'd3;
        tick();
        load[2] = 1'b0;
        checks++;
        if (q[2] !== 4'd3) begin errors++; $display("FAIL load_pre_q: got %0d want 3", q[2]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q[2] !== 4'(exp_q[i])) begin errors++; $display("FAIL load_pre_restart %0d: got %0d want %0d", i, q[2], exp_q[i]); end
        end
        en[2] = 1'b0;
    endtask

    task automatic test_prescale();
        bit en_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int exp_q  [4] = '{0, 0, 0, 1};
        bit exp_tc [3] = '{1'b0, 1'b0, 1'b1};
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0; up_dn[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[2] = en_pat[i];
            tick();
            checks++;
            if (q[2] !== 4'(exp_q[i])) begin errors++; $display("FAIL prescale_q cycle %0d: got %0d want %0d", i, q[2], exp_q[i]); end
        end
        en[2] = 1'b0; load[2] = 1'b1; load_val[2] = 4'd9;
        tick();
        load[2] = 1'b0; en[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (tc[2] !== exp_tc[i]) begin errors++; $display("FAIL prescale_tc cycle %0d: got %b want %b", i, tc[2], exp_tc[i]); end
            tick();
        end
        checks++;
        if (q[2] !== 4'd0) begin errors++; $display("FAIL prescale_wrap_q: got %0d want 0", q[2]); end
        checks++;
        if (ovf[2] !== 1'b1) begin errors++; $display("FAIL prescale_ovf: got %b want 1", ovf[2]); end
        en[2] = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit dirs  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int exp_q [5] = '{6, 7, 6, 5, 6};
        load[0] = 1'b1; load_val[0] = 4'd5;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_dn[0] = dirs[i];
            tick();
            checks++;
            if (q[0] !== 4'(exp_q[i])) begin errors++; $display("FAIL direction cycle %0d: got %0d want %0d", i, q[0], exp_q[i]); end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_ovf();
        // ovf is still set from the earlier down-wrap on instance 0.
        clr_ovf[0] = 1'b1;
        tick();
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf[0]); end
        clr_ovf[0] = 1'b0; load[0] = 1'b1; load_val[0] = 4'd9;
        tick();
        load[0] = 1'b0; en[0] = 1'b1; up_dn[0] = 1'b1; clr_ovf[0] = 1'b1;
        #1;
        checks++;
        if (tc[0] !== 1'b1) begin errors++; $display("FAIL ovf_tc: got %b want 1", tc[0]); end
        tick();
        checks++;
        if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf[0]); end
        checks++;
        if (q[0] !== 4'd0) begin errors++; $display("FAIL ovf_wrap_q: got %0d want 0", q[0]); end
        en[0] = 1'b0;
        tick();
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_clear2: got %b want 0", ovf[0]); end
        clr_ovf[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_prescale();
        test_back_to_back();
        test_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sync_mod_counter
